// File: rtl/pio_in_irq_debounced.sv
// pio_in_irq_debounced
// Avalon-MM input PIO with per-bit synchroniser, debounce filter, edge capture
// and a maskable level interrupt. Four word registers:
//   0 data (RO), 1 reserved (RO, 0), 2 irqmask (RW), 3 edgecapture (W1C).
module pio_in_irq_debounced #(
    parameter int unsigned WIDTH        = 4,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned DEBOUNCE_CYC = 50000,
    parameter int unsigned EDGE_TYPE    = 0,
    parameter logic [31:0] RESET_VALUE  = 32'h0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    // Counter wide enough to hold DEBOUNCE_CYC-1; kept at least one bit wide
    // so the declaration stays legal for the tiny and bypass settings.
    localparam int unsigned CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((DEBOUNCE_CYC > 0) ? (DEBOUNCE_CYC - 1) : 0);
    localparam logic [WIDTH-1:0] RST_V = RESET_VALUE[WIDTH-1:0];

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_reg;
    logic [WIDTH-1:0] sync_out;
    logic [WIDTH-1:0] stable_vec;
    logic [WIDTH-1:0] prev_reg;
    logic [WIDTH-1:0] edge_vec;
    logic [WIDTH-1:0] clr_vec;
    logic [WIDTH-1:0] edgecapture_reg;
    logic [WIDTH-1:0] irqmask_reg;
    logic             wr_en;

    // Data bits above WIDTH are intentionally ignored on writes.
    logic unused_writedata;
    assign unused_writedata = &{1'b0, writedata};

    assign wr_en    = chipselect & ~write_n;
    assign sync_out = sync_reg[SYNC_STAGES-1];

    // Shift the raw pins through the synchroniser chain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_reg <= {SYNC_STAGES{RST_V}};
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], in_port};
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic stable_bit_reg;
            assign stable_vec[gi] = stable_bit_reg;

            if (DEBOUNCE_CYC == 0) begin : g_bypass
                // No filtering: the debounced state follows the synchroniser.
                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        stable_bit_reg <= RST_V[gi];
                    end else begin
                        stable_bit_reg <= sync_out[gi];
                    end
                end
            end else begin : g_filter
                logic [CNT_W-1:0] cnt_reg;
                // Accept a change only after DEBOUNCE_CYC consecutive differing samples.
                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        cnt_reg        <= '0;
                        stable_bit_reg <= RST_V[gi];
                    end else if (sync_out[gi] == stable_bit_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        stable_bit_reg <= sync_out[gi];
                        cnt_reg        <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end
        end
    endgenerate

    // Remember last cycle's debounced state for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_reg <= RST_V;
        end else begin
            prev_reg <= stable_vec;
        end
    end

    // Select edge polarity and decode the W1C clear mask.
    always_comb begin
        edge_vec = stable_vec ^ prev_reg;
        if (EDGE_TYPE == 0) begin
            edge_vec = stable_vec & ~prev_reg;
        end else if (EDGE_TYPE == 1) begin
            edge_vec = ~stable_vec & prev_reg;
        end
        clr_vec = '0;
        if (wr_en && address == 2'd3) begin
            clr_vec = writedata[WIDTH-1:0];
        end
    end

    // Edge capture: a new edge wins over a simultaneous clear so none are lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edgecapture_reg <= '0;
        end else begin
            edgecapture_reg <= edge_vec | (edgecapture_reg & ~clr_vec);
        end
    end

    // Interrupt mask register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask_reg <= '0;
        end else if (wr_en && address == 2'd2) begin
            irqmask_reg <= writedata[WIDTH-1:0];
        end
    end

    // Registered read mux; reads have no side effects.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            case (address)
                2'd0:    readdata <= 32'(stable_vec);
                2'd2:    readdata <= 32'(irqmask_reg);
                2'd3:    readdata <= 32'(edgecapture_reg);
                default: readdata <= 32'h0;
            endcase
        end
    end

    // Registered level interrupt.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq <= 1'b0;
        end else begin
            irq <= |(edgecapture_reg & irqmask_reg);
        end
    end

endmodule

// File: tb/tb_pio_in_irq_debounced.sv
// Testbench for pio_in_irq_debounced: directed steps followed by random
// traffic, all checked against a cycle-level behavioural model.
module tb_pio_in_irq_debounced;

    localparam int unsigned W  = 4;
    localparam int unsigned S  = 2;
    localparam int unsigned D  = 8;
    localparam int unsigned E  = 1;
    localparam logic [3:0]  RV = 4'hF;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'h0;
    logic [3:0]  in_port = RV;
    logic [31:0] readdata;
    logic        irq;

    always #5 clk = ~clk;

    pio_in_irq_debounced #(
        .WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYC(D), .EDGE_TYPE(E),
        .RESET_VALUE(32'hF)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(readdata), .irq(irq)
    );

    // Behavioural model state
    logic [3:0]  m_sync [S];
    logic [3:0]  m_stable, m_prev, m_edgecap, m_mask;
    int          m_run [W];
    logic [31:0] m_rd;
    logic        m_irq;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic model_reset();
        for (int i = 0; i < int'(S); i++) m_sync[i] = RV;
        m_stable = RV; m_prev = RV; m_edgecap = 4'h0; m_mask = 4'h0;
        for (int b = 0; b < int'(W); b++) m_run[b] = 0;
        m_rd = 32'h0; m_irq = 1'b0;
    endtask

    function automatic logic [3:0] m_edge();
        if (E == 0) return m_stable & ~m_prev;
        else if (E == 1) return ~m_stable & m_prev;
        else return m_stable ^ m_prev;
    endfunction

    // One rising edge of the model: everything computed from pre-edge values.
    task automatic model_clock();
        logic [3:0]  clr, edg, nstable, nedgecap, nmask, last;
        logic [31:0] nrd;
        logic        nirq;
        logic        wr;
        wr   = chipselect && !write_n;
        clr  = (wr && address == 2'd3) ? writedata[3:0] : 4'h0;
        nmask = (wr && address == 2'd2) ? writedata[3:0] : m_mask;
        case (address)
            2'd0:    nrd = {28'h0, m_stable};
            2'd2:    nrd = {28'h0, m_mask};
            2'd3:    nrd = {28'h0, m_edgecap};
            default: nrd = 32'h0;
        endcase
        nirq     = |(m_edgecap & m_mask);
        edg      = m_edge();
        nedgecap = edg | (m_edgecap & ~clr);
        last     = m_sync[S-1];
        nstable  = m_stable;
        for (int b = 0; b < int'(W); b++) begin
            if (D == 0) begin
                nstable[b] = last[b];
            end else if (last[b] != m_stable[b]) begin
                m_run[b] = m_run[b] + 1;
                if (m_run[b] == int'(D)) begin
                    nstable[b] = last[b];
                    m_run[b]   = 0;
                end
            end else begin
                m_run[b] = 0;
            end
        end
        m_prev = m_stable; m_stable = nstable; m_edgecap = nedgecap;
        m_mask = nmask; m_rd = nrd; m_irq = nirq;
        for (int i = int'(S) - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
        m_sync[0] = in_port;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset_n) model_clock(); else model_reset();
        @(negedge clk);
    endtask

    task automatic tick_chk(input string tag);
        tick();
        check({tag, " rd"}, readdata, m_rd);
        check({tag, " irq"}, {31'b0, irq}, {31'b0, m_irq});
    endtask

    task automatic avalon_write(input logic [1:0] a, input logic [31:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
        tick_chk("write");
        chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        logic [3:0] ev;
        logic found;
        int r;

        // Step 1: reset with inputs at the reset value
        model_reset();
        repeat (3) tick();
        check("reset readdata", readdata, 32'h0);
        check("reset irq", {31'b0, irq}, 32'h0);
        reset_n = 1'b1;
        address = 2'd0;
        repeat (3) tick_chk("idle");
        check("data after reset", readdata, 32'hF);
        address = 2'd3; tick_chk("rd3");
        check("edgecap after reset", readdata, 32'h0);
        address = 2'd1; tick_chk("rd1");
        check("reserved read", readdata, 32'h0);
        check("irq idle", {31'b0, irq}, 32'h0);

        // Step 2: 5-cycle glitch on bit 0 is filtered out
        address = 2'd0;
        in_port = 4'hE;
        repeat (5) tick_chk("glitch");
        in_port = 4'hF;
        repeat (15) tick_chk("glitch end");
        check("glitch data", readdata, 32'hF);
        address = 2'd3; tick_chk("glitch rd3");
        check("glitch edgecap", readdata, 32'h0);

        // Step 3: sustained drop on bit 0, measure latency
        address = 2'd0;
        in_port = 4'hE;
        tick_chk("capture edge");
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick_chk("latency poll");
            cnt++;
            if (readdata[3:0] == 4'hE) break;
        end
        check("data latency", cnt, S + D);
        address = 2'd3; tick_chk("ec poll");
        check("edgecap set", readdata, 32'h1);
        check("irq masked", {31'b0, irq}, 32'h0);

        // Step 4: unmask, then W1C
        avalon_write(2'd2, 32'h1);
        check("irq same cycle as mask", {31'b0, irq}, 32'h0);
        address = 2'd3; tick_chk("irq up");
        check("irq after mask", {31'b0, irq}, 32'h1);
        avalon_write(2'd3, 32'h1);
        tick_chk("irq down");
        check("irq after w1c", {31'b0, irq}, 32'h0);
        check("edgecap after w1c", readdata, 32'h0);

        // Step 5: falling edge on bit 1 aligned with a W1C of bit 1
        in_port = 4'hC;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            ev = m_edge();
            if (ev[1]) begin
                found = 1'b1;
                break;
            end
            tick_chk("wait edge1");
        end
        check("edge1 found", {31'b0, found}, 32'h1);
        avalon_write(2'd3, 32'h2);
        address = 2'd3; tick_chk("edge vs clr");
        check("edge beats clear", readdata & 32'h2, 32'h2);

        // Step 6: reset in the middle of a bit-2 debounce
        avalon_write(2'd3, 32'hF);
        in_port = 4'h8;
        for (int i = 0; i < 20; i++) begin
            if (m_run[2] == 4) break;
            tick_chk("debounce b2");
        end
        check("b2 debounce progress", m_run[2], 4);
        #2 reset_n = 1'b0;
        #1;
        check("async reset readdata", readdata, 32'h0);
        check("async reset irq", {31'b0, irq}, 32'h0);
        in_port = 4'hF;
        @(negedge clk);
        model_reset();
        repeat (2) tick();
        reset_n = 1'b1;
        address = 2'd0;
        repeat (20) tick_chk("post reset");
        check("post reset data", readdata, 32'hF);
        address = 2'd3; tick_chk("post reset rd3");
        check("post reset edgecap", readdata, 32'h0);
        address = 2'd2; tick_chk("post reset rd2");
        check("post reset mask", readdata, 32'h0);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) in_port = in_port ^ (4'h1 << $urandom_range(0, 3));
            r = int'($urandom_range(0, 9));
            address    = 2'($urandom_range(0, 3));
            writedata  = $urandom;
            chipselect = 1'($urandom_range(0, 1));
            write_n    = 1'b1;
            if (r == 0) begin
                address = 2'd2; chipselect = 1'b1; write_n = 1'b0;
            end else if (r == 1) begin
                address = 2'd3; chipselect = 1'b1; write_n = 1'b0;
            end else if (r == 2) begin
                address = 2'($urandom_range(0, 1)); chipselect = 1'b1; write_n = 1'b0;
            end else if (r == 3) begin
                chipselect = 1'b0; write_n = 1'b0;
            end
            tick_chk("random");
        end
        chipselect = 1'b0; write_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
